// File: rtl/tcam_match_pipe_if.sv
// Rule-write bus plus lookup request/result handshake for tcam_match_pipe.
// master drives writes, keys and out_ready; slave is the match pipeline.
interface tcam_match_pipe_if #(
  parameter int KEY_W = 8,
  parameter int IDX_W = 2
);
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [KEY_W-1:0] wr_value;
  logic [KEY_W-1:0] wr_mask;
  logic             wr_vld;
  logic             in_valid;
  logic             in_ready;
  logic [KEY_W-1:0] in_key;
  logic             out_valid;
  logic             out_ready;
  logic             out_hit;
  logic [IDX_W-1:0] out_idx;
  logic             out_multi;

  modport master (
    output wr_en, wr_idx, wr_value, wr_mask, wr_vld, in_valid, in_key, out_ready,
    input  in_ready, out_valid, out_hit, out_idx, out_multi
  );

  modport slave (
    input  wr_en, wr_idx, wr_value, wr_mask, wr_vld, in_valid, in_key, out_ready,
    output in_ready, out_valid, out_hit, out_idx, out_multi
  );
endinterface

// File: rtl/tcam_match_pipe.sv
// Two-stage ternary match pipeline: S1 registers the match vector, S2 priority-encodes it.
// Define TCAM_MATCH_STATS_EN to add saturating hit/miss counters with a clr_stats input.
module tcam_match_pipe #(
  parameter int KEY_W   = 8,
  parameter int ENTRIES = 4,
  parameter int IDX_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef TCAM_MATCH_STATS_EN
  input  logic              clr_stats,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
`endif
  tcam_match_pipe_if.slave  bus
);

  logic [ENTRIES-1:0] ent_vld;
  logic [KEY_W-1:0]   ent_value [ENTRIES];
  logic [KEY_W-1:0]   ent_mask  [ENTRIES];

  logic [ENTRIES-1:0] match_vec;
  logic               s1_full;
  logic [ENTRIES-1:0] s1_vec;
  logic               s2_load;
  logic               accept;
  logic               wr_hit;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_hit;
  logic               enc_multi;

  // The extra index bit lets out-of-range write indices be rejected for any ENTRIES.
  assign wr_hit  = bus.wr_en && ({1'b0, bus.wr_idx} < (IDX_W+1)'(ENTRIES));
  assign s2_load = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_full || s2_load;
  assign accept  = bus.in_valid && bus.in_ready;

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < ENTRIES; i++)
      match_vec[i] = ent_vld[i] && (((bus.in_key ^ ent_value[i]) & ent_mask[i]) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_vld <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ent_value[i] <= '0;
        ent_mask[i]  <= '0;
      end
    end else if (wr_hit) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (bus.wr_idx == IDX_W'(i)) begin
          ent_vld[i]   <= bus.wr_vld;
          ent_value[i] <= bus.wr_value;
          ent_mask[i]  <= bus.wr_mask;
        end
      end
    end
  end

  // The vector is frozen at acceptance, so later rule writes cannot alter it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full <= 1'b0;
      s1_vec  <= '0;
    end else if (accept) begin
      s1_full <= 1'b1;
      s1_vec  <= match_vec;
    end else if (s2_load) begin
      s1_full <= 1'b0;
    end
  end

  // Scan from the top so the lowest set bit is the one left in enc_idx.
  always_comb begin
    enc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (s1_vec[i]) enc_idx = IDX_W'(i);
  end

  assign enc_hit   = |s1_vec;
  assign enc_multi = |(s1_vec & (s1_vec - ENTRIES'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_hit   <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_multi <= 1'b0;
    end else if (s2_load) begin
      bus.out_valid <= s1_full;
      if (s1_full) begin
        bus.out_hit   <= enc_hit;
        bus.out_idx   <= enc_idx;
        bus.out_multi <= enc_multi;
      end
    end
  end

`ifdef TCAM_MATCH_STATS_EN
  logic out_fire;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (clr_stats) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (out_fire) begin
      if (bus.out_hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tcam_match_pipe.sv
// Randomized and directed bench for tcam_match_pipe with an in-bench behavioural model.
// Compile with TCAM_MATCH_STATS_EN defined to also exercise the hit/miss counters.
module tb_tcam_match_pipe;
  localparam int KEY_W   = 8;
  localparam int ENTRIES = 4;
  localparam int IDX_W   = 2;

  typedef struct {
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             multi;
    int unsigned      acc_cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tcam_match_pipe_if #(.KEY_W(KEY_W), .IDX_W(IDX_W)) bus ();

`ifdef TCAM_MATCH_STATS_EN
  logic        clr_stats;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  int unsigned m_hits, m_misses;
`endif

  tcam_match_pipe #(.KEY_W(KEY_W), .ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef TCAM_MATCH_STATS_EN
    .clr_stats(clr_stats),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
`endif
    .bus      (bus.slave)
  );

  logic             m_vld [ENTRIES];
  logic [KEY_W-1:0] m_val [ENTRIES];
  logic [KEY_W-1:0] m_msk [ENTRIES];
  res_t             exp_q[$];
  res_t             got_q[$];
  int unsigned      cyc;
  int               n_checks;
  int               n_fail;
  logic             mon_ov, mon_ir, mon_fire;
  res_t             mon_r;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference lookup: count every valid entry whose cared-for bits agree with the key.
  function automatic res_t model_lookup(input logic [KEY_W-1:0] key);
    res_t r;
    int   cnt = 0;
    r.hit = 1'b0; r.idx = '0; r.multi = 1'b0; r.acc_cyc = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_vld[i] && ((key & m_msk[i]) == (m_val[i] & m_msk[i]))) begin
        if (cnt == 0) r.idx = IDX_W'(i);
        cnt++;
      end
    end
    r.hit   = (cnt > 0);
    r.multi = (cnt > 1);
    return r;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < ENTRIES; i++) begin
      m_vld[i] = 1'b0; m_val[i] = '0; m_msk[i] = '0;
    end
    exp_q.delete();
    got_q.delete();
`ifdef TCAM_MATCH_STATS_EN
    m_hits = 0; m_misses = 0;
`endif
  endtask

  // An item accepted at edge a is visible from edge a+1 onward while it heads the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_ov   = (exp_q.size() > 0) && (exp_q[0].acc_cyc < cyc);
      mon_ir   = (exp_q.size() < 2) || bus.out_ready;
      mon_fire = mon_ov && bus.out_ready;
      checkOutput("out_valid", bus.out_valid, mon_ov);
      checkOutput("in_ready", bus.in_ready, mon_ir);
`ifdef TCAM_MATCH_STATS_EN
      checkOutput("hit_cnt", hit_cnt, m_hits);
      checkOutput("miss_cnt", miss_cnt, m_misses);
      if (clr_stats) begin
        m_hits = 0; m_misses = 0;
      end else if (mon_fire) begin
        if (exp_q[0].hit) begin
          if (m_hits < 16'hFFFF) m_hits++;
        end else if (m_misses < 16'hFFFF) m_misses++;
      end
`endif
      if (mon_ov) begin
        checkOutput("out_hit", bus.out_hit, exp_q[0].hit);
        checkOutput("out_idx", bus.out_idx, exp_q[0].idx);
        checkOutput("out_multi", bus.out_multi, exp_q[0].multi);
        if (mon_fire) begin
          mon_r.hit = bus.out_hit; mon_r.idx = bus.out_idx;
          mon_r.multi = bus.out_multi; mon_r.acc_cyc = cyc;
          got_q.push_back(mon_r);
          void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && mon_ir) begin
        mon_r = model_lookup(bus.in_key);
        mon_r.acc_cyc = cyc + 1;
        exp_q.push_back(mon_r);
      end
      if (bus.wr_en && (int'(bus.wr_idx) < ENTRIES)) begin
        m_vld[bus.wr_idx] = bus.wr_vld;
        m_val[bus.wr_idx] = bus.wr_value;
        m_msk[bus.wr_idx] = bus.wr_mask;
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [IDX_W-1:0] wi,
                               input logic [KEY_W-1:0] wv, input logic [KEY_W-1:0] wm,
                               input logic wvl, input logic iv, input logic [KEY_W-1:0] key,
                               input logic ordy, output logic accepted);
    bus.wr_en = we; bus.wr_idx = wi; bus.wr_value = wv; bus.wr_mask = wm; bus.wr_vld = wvl;
    bus.in_valid = iv; bus.in_key = key; bus.out_ready = ordy;
    @(negedge clk);
    accepted = iv && bus.in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, '0, 0, 0, '0, 1, acc);
  endtask

  task automatic writeEntry(input logic [IDX_W-1:0] wi, input logic [KEY_W-1:0] wv,
                            input logic [KEY_W-1:0] wm, input logic wvl);
    logic acc;
    applyStimulus(1, wi, wv, wm, wvl, 0, '0, 1, acc);
  endtask

  task automatic waitResults(input int target, input string name);
    for (int i = 0; i < 30 && got_q.size() < target; i++) idle(1);
    if (got_q.size() < target) checkOutput({name, " timeout"}, got_q.size(), target);
  endtask

  task automatic doLookup(input logic [KEY_W-1:0] key, input logic eh, input logic [IDX_W-1:0] ei,
                          input logic em, input string name);
    int   n0 = got_q.size();
    logic acc;
    applyStimulus(0, '0, '0, '0, 0, 1, key, 1, acc);
    checkOutput({name, " accepted"}, acc, 1);
    waitResults(n0 + 1, name);
    if (got_q.size() > n0) begin
      checkOutput({name, " hit"}, got_q[n0].hit, eh);
      checkOutput({name, " idx"}, got_q[n0].idx, ei);
      checkOutput({name, " multi"}, got_q[n0].multi, em);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("reset out_valid", bus.out_valid, 0);
    clearModel();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [KEY_W-1:0] keys [6];
    logic [IDX_W-1:0] kidx [6];
    logic acc, saw_stall;
    int   n0, sent;
    n_checks = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b1;
    bus.wr_en = 0; bus.wr_idx = '0; bus.wr_value = '0; bus.wr_mask = '0; bus.wr_vld = 0;
    bus.in_valid = 0; bus.in_key = '0; bus.out_ready = 1;
`ifdef TCAM_MATCH_STATS_EN
    clr_stats = 1'b0;
`endif
    #1;
    doReset();
    checkOutput("reset out_hit", bus.out_hit, 0);
    checkOutput("reset out_idx", bus.out_idx, 0);
    checkOutput("reset out_multi", bus.out_multi, 0);
    checkOutput("reset in_ready", bus.in_ready, 1);

    doLookup(8'h00, 0, 0, 0, "empty table");
    writeEntry(2, 8'hA5, 8'hFF, 1);
    doLookup(8'hA5, 1, 2, 0, "exact A5");
    doLookup(8'hA4, 0, 0, 0, "exact A4 miss");
    writeEntry(1, 8'hA0, 8'hF0, 1);
    writeEntry(3, 8'h00, 8'h00, 1);
    doLookup(8'hA5, 1, 1, 1, "multi A5");
    doLookup(8'h5A, 1, 3, 0, "wildcard 5A");

    // Write entry 0 and look up its key in the same cycle, then again one cycle later.
    n0 = got_q.size();
    applyStimulus(1, 0, 8'h33, 8'hFF, 1, 1, 8'h33, 1, acc);
    applyStimulus(0, '0, '0, '0, 0, 1, 8'h33, 1, acc);
    waitResults(n0 + 2, "same-cycle write");
    if (got_q.size() >= n0 + 2) begin
      checkOutput("old-table idx", got_q[n0].idx, 3);
      checkOutput("old-table multi", got_q[n0].multi, 0);
      checkOutput("new-table idx", got_q[n0+1].idx, 0);
      checkOutput("new-table multi", got_q[n0+1].multi, 1);
    end

    // Back-to-back stream with out_ready low on cycles 3..5.
    keys = '{8'hA5, 8'h5A, 8'h33, 8'hA4, 8'h00, 8'hFF};
    kidx = '{2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd3};
    n0 = got_q.size(); sent = 0; saw_stall = 0;
    for (int c = 0; c < 40 && got_q.size() < n0 + 6; c++) begin
      applyStimulus(0, '0, '0, '0, 0, sent < 6, keys[sent < 6 ? sent : 0],
                    !(c >= 3 && c <= 5), acc);
      if (sent < 6 && !acc) saw_stall = 1;
      if (acc) sent++;
    end
    checkOutput("stream stall seen", saw_stall, 1);
    checkOutput("stream count", got_q.size() - n0, 6);
    for (int i = 0; i < 6 && n0 + i < got_q.size(); i++)
      checkOutput($sformatf("stream idx %0d", i), got_q[n0+i].idx, kidx[i]);

    // Random traffic: sparse masks keep the hit rate useful.
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 7) == 0, IDX_W'($urandom_range(0, ENTRIES - 1)),
                    KEY_W'($urandom), KEY_W'($urandom & $urandom & $urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    KEY_W'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    idle(10);

    // Reset with two lookups in flight.
    applyStimulus(0, '0, '0, '0, 0, 1, 8'hA5, 1, acc);
    applyStimulus(0, '0, '0, '0, 0, 1, 8'h5A, 1, acc);
    doReset();
    doLookup(8'hA5, 0, 0, 0, "post-reset A5");
    doLookup(8'h00, 0, 0, 0, "post-reset 00");
    checkOutput("post-reset result count", got_q.size(), 2);

`ifdef TCAM_MATCH_STATS_EN
    clr_stats = 1'b1; idle(1); clr_stats = 1'b0;
    writeEntry(0, 8'hA5, 8'hFF, 1);
    for (int i = 0; i < 3; i++) doLookup(8'hA5, 1, 0, 0, "stats hit");
    for (int i = 0; i < 2; i++) doLookup(8'h11, 0, 0, 0, "stats miss");
    idle(2);
    checkOutput("stats hit_cnt 3", hit_cnt, 3);
    checkOutput("stats miss_cnt 2", miss_cnt, 2);
    clr_stats = 1'b1; idle(1); clr_stats = 1'b0;
    idle(1);
    checkOutput("stats hit_cnt clr", hit_cnt, 0);
    checkOutput("stats miss_cnt clr", miss_cnt, 0);
`endif

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
